ad9826_init_seq: RTL and testbench

Configuration sequencer for the AD9826 CCD front-end. On a `start` pulse it walks a 8-entry register table and issues one write transaction per enabled register to the serial configuration engine (`ad9826_config`) over a req/ack handshake. When `VERIFY`=1 it reads each register back and compares it. It sits between the control/register block and the serial engine, and is the only master of that engine.

---
 rtl/ad9826_init_seq.sv | 164 ++++++++++++++++
 tb/tb_ad9826_init_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9826_init_seq.sv
// Configuration sequencer for the AD9826 CCD front-end: walks an 8-entry register
// table and issues write (and optional readback) transactions to the serial engine.
module ad9826_init_seq #(
   parameter bit          VERIFY  = 1'b1,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [71:0] reg_table,
   input  logic [7:0]  reg_mask,
   output logic [15:0] cfg_word,
   output logic        cfg_req,
   input  logic        cfg_ack,
   input  logic [8:0]  cfg_rdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [2:0]  err_addr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_WR_REQ,
      S_WR_WAIT,
      S_RD_REQ,
      S_RD_WAIT,
      S_DONE
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [8:0]  tbl [8];
   logic [7:0]  mask;
   logic [2:0]  idx;
   logic [15:0] tmo_cnt;
   logic [8:0]  cur_val;
   logic        last;

   assign cur_val = tbl[idx];
   assign last    = (idx == 3'd7);

   // NOTE: the latched table is plain storage with no reset; it is always
   // rewritten on an accepted start before any state reads it.
   always_ff @(posedge clk) begin
      if (start && !done && state == S_IDLE && !rst) begin
         for (int i = 0; i < 8; i++) begin
            tbl[i] <= reg_table[i*9 +: 9];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         mask     <= '0;
         idx      <= '0;
         tmo_cnt  <= '0;
         cfg_req  <= 1'b0;
         cfg_word <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         err_code <= 2'b00;
         err_addr <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // The cycle that shows done is still part of the finished sequence.
               if (start && !done) begin
                  mask     <= reg_mask;
                  idx      <= '0;
                  error    <= 1'b0;
                  err_code <= 2'b00;
                  err_addr <= '0;
                  busy     <= 1'b1;
                  state    <= S_SCAN;
               end
            end

            S_SCAN: begin
               if (mask[idx])  state <= S_WR_REQ;
               else if (last)  state <= S_DONE;
               else            idx   <= idx + 3'd1;
            end

            S_WR_REQ: begin
               cfg_word <= {1'b0, idx, 3'b000, cur_val};
               cfg_req  <= 1'b1;
               tmo_cnt  <= '0;
               state    <= S_WR_WAIT;
            end

            S_WR_WAIT: begin
               if (cfg_ack) begin
                  cfg_req <= 1'b0;
                  if (VERIFY) begin
                     state <= S_RD_REQ;
                  end else if (last) begin
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 3'd1;
                     state <= S_SCAN;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  cfg_req  <= 1'b0;
                  error    <= 1'b1;
                  err_code <= 2'b10;
                  err_addr <= idx;
                  state    <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end

            S_RD_REQ: begin
               cfg_word <= {1'b1, idx, 12'h000};
               cfg_req  <= 1'b1;
               tmo_cnt  <= '0;
               state    <= S_RD_WAIT;
            end

            S_RD_WAIT: begin
               if (cfg_ack) begin
                  cfg_req <= 1'b0;
                  // Only the first mismatch is recorded; the sequence carries on.
                  if (cfg_rdata != cur_val && !error) begin
                     error    <= 1'b1;
                     err_code <= 2'b01;
                     err_addr <= idx;
                  end
                  if (last) begin
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 3'd1;
                     state <= S_SCAN;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  cfg_req  <= 1'b0;
                  error    <= 1'b1;
                  err_code <= 2'b10;
                  err_addr <= idx;
                  state    <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end

            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad9826_init_seq.sv
// Bench for ad9826_init_seq: two instances (readback on / write-only) driven by a
// behavioural engine model; results compared against hand vectors and a sequence model.
module tb_ad9826_init_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [71:0] tbl_in;
   logic [7:0]  mask_in;
   logic        start [2];
   logic [15:0] word  [2];
   logic        req   [2];
   logic        ack   [2];
   logic [8:0]  rdata [2];
   logic        busy  [2];
   logic        done  [2];
   logic        error [2];
   logic [1:0]  code  [2];
   logic [2:0]  eaddr [2];

   ad9826_init_seq #(.VERIFY(1'b1), .TIMEOUT(32)) dut_v (
      .clk(clk), .rst(rst), .start(start[0]), .reg_table(tbl_in), .reg_mask(mask_in),
      .cfg_word(word[0]), .cfg_req(req[0]), .cfg_ack(ack[0]), .cfg_rdata(rdata[0]),
      .busy(busy[0]), .done(done[0]), .error(error[0]), .err_code(code[0]), .err_addr(eaddr[0]));

   ad9826_init_seq #(.VERIFY(1'b0), .TIMEOUT(16)) dut_w (
      .clk(clk), .rst(rst), .start(start[1]), .reg_table(tbl_in), .reg_mask(mask_in),
      .cfg_word(word[1]), .cfg_req(req[1]), .cfg_ack(ack[1]), .cfg_rdata(rdata[1]),
      .busy(busy[1]), .done(done[1]), .error(error[1]), .err_code(code[1]), .err_addr(eaddr[1]));

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Engine model: acks 'lat' cycles after req rises (0 = never), never acks muted
   // addresses, returns written data on reads with bit 0 flipped for 'bad' addresses.
   int          lat;
   logic [7:0]  bad, mute;
   logic [8:0]  eng_mem [8];
   logic [15:0] log0 [$];
   logic [15:0] log1 [$];
   logic [15:0] held [2];
   bit          req_prev [2];
   bit          ack_prev [2];
   int          cnt [2];
   int          last_hi [2];

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (ack_prev[d]) check("req_gap_after_ack", 32'(req[d]), 32'd0);
         ack_prev[d] = 1'b0;
         ack[d]      = 1'b0;
         rdata[d]    = 9'($urandom);
         if (req[d] === 1'b1) begin
            if (!req_prev[d]) begin
               held[d] = word[d];
               cnt[d]  = 0;
               if (d == 0) log0.push_back(word[d]);
               else        log1.push_back(word[d]);
            end else begin
               check("word_stable", 32'(word[d]), 32'(held[d]));
            end
            cnt[d]++;
            if (lat != 0 && !mute[word[d][14:12]] && cnt[d] == lat) begin
               ack[d]      = 1'b1;
               ack_prev[d] = 1'b1;
               if (word[d][15])
                  rdata[d] = eng_mem[word[d][14:12]] ^ (bad[word[d][14:12]] ? 9'h001 : 9'h000);
               else
                  eng_mem[word[d][14:12]] = word[d][8:0];
            end
         end else if (req_prev[d]) begin
            last_hi[d] = cnt[d];
         end
         req_prev[d] = (req[d] === 1'b1);
      end
   end

   function automatic int log_size(input int d);
      return (d == 0) ? log0.size() : log1.size();
   endfunction

   function automatic logic [15:0] log_at(input int d, input int i);
      return (d == 0) ? log0[i] : log1[i];
   endfunction

   // Sequence model: transaction list, error outcome and start-to-done cycle count,
   // built from per-index costs (1 scan cycle, 1 + latency per transaction, 1 done cycle).
   logic [15:0] exp_q [$];
   logic [1:0]  exp_code;
   logic [2:0]  exp_addr;
   int          exp_cyc;

   task automatic model(input logic [7:0] m, input bit ver, input int l, input logic [7:0] b,
                        input logic [7:0] mu, input int tmo, input logic [71:0] t);
      exp_q.delete();
      exp_code = 2'b00;
      exp_addr = 3'd0;
      exp_cyc  = 1;
      for (int i = 0; i < 8; i++) begin
         exp_cyc++;
         if (m[i]) begin
            exp_q.push_back({1'b0, 3'(i), 3'b000, t[i*9 +: 9]});
            if (mu[i] || l == 0 || l > tmo) begin
               exp_cyc += 1 + tmo;
               exp_code = 2'b10;
               exp_addr = 3'(i);
               break;
            end
            exp_cyc += 1 + l;
            if (ver) begin
               exp_q.push_back({1'b1, 3'(i), 12'h000});
               exp_cyc += 1 + l;
               if (b[i] && exp_code == 2'b00) begin
                  exp_code = 2'b01;
                  exp_addr = 3'(i);
               end
            end
         end
      end
   endtask

   int meas;

   task automatic run_seq(input int d, input logic [7:0] m, input logic [71:0] t);
      tbl_in  = t;
      mask_in = m;
      if (d == 0) log0.delete(); else log1.delete();
      @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      // Scramble the inputs: the running sequence must use the latched copy.
      tbl_in  = {8'($urandom), $urandom, $urandom};
      mask_in = 8'($urandom);
      meas = 0;
      for (int n = 1; n <= 2000; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check("busy_after_start", 32'(busy[d]), 32'd1);
            check("error_cleared", 32'(error[d]), 32'd0);
         end
         if (done[d] === 1'b1) begin
            meas = n;
            break;
         end
      end
      if (meas == 0) check("done_within_budget", 32'd0, 32'd1);
   endtask

   task automatic verify(input int d, input int v_cyc, input logic [1:0] v_code, input logic [2:0] v_addr);
      check("cycles_to_done", 32'(meas), 32'(v_cyc));
      check("err_code", 32'(code[d]), 32'(v_code));
      check("err_addr", 32'(eaddr[d]), 32'(v_addr));
      check("error_flag", 32'(error[d]), 32'(v_code != 2'b00));
      check("busy_at_done", 32'(busy[d]), 32'd0);
      check("n_transactions", 32'(log_size(d)), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_size(d); i++)
         check("cfg_word", 32'(log_at(d, i)), 32'(exp_q[i]));
      @(negedge clk);
      check("done_one_cycle", 32'(done[d]), 32'd0);
   endtask

   typedef struct {
      int         dut;
      logic [7:0] mask;
      int         lat;
      logic [7:0] bad;
      logic [7:0] mute;
      logic [1:0] code;
      logic [2:0] addr;
      int         cyc;
   } vec_t;

   vec_t        vecs [11];
   logic [71:0] tbl_fix;

   initial begin
      int dcount, dat, tmo, sel, d;
      bit busy_again;
      logic [7:0]  r_mask;
      logic [71:0] r_tbl;

      rst      = 1'b1;
      start[0] = 1'b0;
      start[1] = 1'b0;
      ack[0]   = 1'b0;
      ack[1]   = 1'b0;
      rdata[0] = '0;
      rdata[1] = '0;
      lat = 1; bad = '0; mute = '0;
      tbl_in = '0; mask_in = '0;
      for (int i = 0; i < 8; i++)
         tbl_fix[i*9 +: 9] = (i == 0 || i == 5) ? 9'h0D8 : 9'(i * 53 + 1);

      vecs[0]  = '{0, 8'h01, 20, 8'h00, 8'h00, 2'b00, 3'd0, 51};
      vecs[1]  = '{0, 8'h21,  3, 8'h20, 8'h00, 2'b01, 3'd5, 25};
      vecs[2]  = '{0, 8'h24,  2, 8'h24, 8'h00, 2'b01, 3'd2, 21};
      vecs[3]  = '{0, 8'h00,  1, 8'h00, 8'h00, 2'b00, 3'd0,  9};
      vecs[4]  = '{0, 8'h08,  0, 8'h00, 8'h00, 2'b10, 3'd3, 38};
      vecs[5]  = '{0, 8'h11,  2, 8'h01, 8'h10, 2'b10, 3'd4, 45};
      vecs[6]  = '{1, 8'hFF,  1, 8'h00, 8'h00, 2'b00, 3'd0, 25};
      vecs[7]  = '{1, 8'h08,  0, 8'h00, 8'h00, 2'b10, 3'd3, 22};
      vecs[8]  = '{1, 8'h08, 16, 8'h00, 8'h00, 2'b00, 3'd0, 26};
      vecs[9]  = '{1, 8'h08, 17, 8'h00, 8'h00, 2'b10, 3'd3, 22};
      vecs[10] = '{0, 8'h80, 32, 8'h00, 8'h00, 2'b00, 3'd0, 75};

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_cfg_req", 32'(req[k]), 32'd0);
         check("rst_cfg_word", 32'(word[k]), 32'd0);
         check("rst_busy", 32'(busy[k]), 32'd0);
         check("rst_done", 32'(done[k]), 32'd0);
         check("rst_error", 32'(error[k]), 32'd0);
         check("rst_err_code", 32'(code[k]), 32'd0);
         check("rst_err_addr", 32'(eaddr[k]), 32'd0);
      end
      rst = 1'b0;

      for (int v = 0; v < 11; v++) begin
         tmo  = (vecs[v].dut == 0) ? 32 : 16;
         lat  = vecs[v].lat;
         bad  = vecs[v].bad;
         mute = vecs[v].mute;
         model(vecs[v].mask, vecs[v].dut == 0, lat, bad, mute, tmo, tbl_fix);
         run_seq(vecs[v].dut, vecs[v].mask, tbl_fix);
         verify(vecs[v].dut, vecs[v].cyc, vecs[v].code, vecs[v].addr);
         if (v == 0) begin
            check("first_write_word", 32'(log_at(0, 0)), 32'h00D8);
            check("first_read_word", 32'(log_at(0, 1)), 32'h8000);
         end
         if (v == 7) check("timeout_req_width", 32'(last_hi[1]), 32'd16);
      end

      // Empty mask with a second start while busy and a start during the done cycle.
      mask_in = 8'h00;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      dcount = 0; dat = 0; busy_again = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (dat != 0 && busy[0] === 1'b1) busy_again = 1'b1;
         start[0] = (n == 3);
         if (done[0] === 1'b1) begin
            dcount++;
            if (dcount == 1) dat = n;
            start[0] = 1'b1;
         end
      end
      start[0] = 1'b0;
      check("empty_mask_done_count", 32'(dcount), 32'd1);
      check("empty_mask_done_edge", 32'(dat), 32'd9);
      check("start_in_done_cycle_ignored", 32'(busy_again), 32'd0);

      // Reset while a request is outstanding, then a normal sequence.
      lat = 0; bad = '0; mute = '0;
      tbl_in = tbl_fix; mask_in = 8'h01;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (req[0] === 1'b1) break;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("req_before_reset", 32'(req[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_cfg_req", 32'(req[0]), 32'd0);
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_error", 32'(error[0]), 32'd0);
      check("midrst_cfg_word", 32'(word[0]), 32'd0);
      check("midrst_done", 32'(done[0]), 32'd0);
      rst = 1'b0;
      lat = 2;
      model(8'h01, 1'b1, lat, bad, mute, 32, tbl_fix);
      run_seq(0, 8'h01, tbl_fix);
      verify(0, exp_cyc, exp_code, exp_addr);

      // Randomized sequences against the model.
      for (int r = 0; r < 24; r++) begin
         d   = int'($urandom_range(0, 1));
         tmo = (d == 0) ? 32 : 16;
         sel = int'($urandom_range(0, 9));
         lat = (sel == 0) ? 0 : (sel == 1) ? tmo : (sel == 2) ? tmo + 1 : int'($urandom_range(1, 6));
         bad  = 8'($urandom);
         mute = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
         r_mask = 8'($urandom);
         r_tbl  = {8'($urandom), $urandom, $urandom};
         model(r_mask, d == 0, lat, bad, mute, tmo, r_tbl);
         run_seq(d, r_mask, r_tbl);
         verify(d, exp_cyc, exp_code, exp_addr);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
